// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and transaction-owner types for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_DATA, OWN_FETCH} owner_t;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: one-deep request holding slot with overrun detection.
module mem_arb_slot #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          grant_i,
  output logic          pend_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          overrun_o
);
  logic          pend_q, pend_d, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          load;
  assign load      = req_i & ~pend_q;
  assign overrun_o = req_i & pend_q;
  // a req that collides with a pending slot is dropped even if that slot is granted now
  assign pend_d    = load | (pend_q & ~grant_i);
  assign pend_o    = pend_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (load) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises host/data/fetch requests onto a toggle-handshake memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int FAIR_MAX = 4,
  parameter int TIMEOUT  = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          h_req,
  input  logic          d_req,
  input  logic          i_req,
  input  logic          h_we,
  input  logic          d_we,
  input  logic [AW-1:0] h_addr,
  input  logic [AW-1:0] d_addr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] h_wdata,
  input  logic [DW-1:0] d_wdata,
  output logic          h_done,
  output logic          d_done,
  output logic          i_done,
  output logic [DW-1:0] rdata,
  output logic          ma_request,
  input  logic          ma_answer,
  output logic [AW-1:0] ma_addr,
  output logic          ma_we,
  output logic [DW-1:0] ma_wdata,
  input  logic [DW-1:0] ma_rdata,
  output logic          busy,
  output logic          err_overrun,
  output logic          err_timeout
);
  localparam int            TW       = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT);
  localparam logic [3:0]    FAIR_LIM = 4'(FAIR_MAX);
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          req_q, req_d, we_q, we_d, eov_q, eov_d, eto_q, eto_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    fair_q, fair_d;
  logic [2:0]    req, pend, grant, ovr, we_in, s_we;
  logic [AW-1:0] addr_in [3];
  logic [AW-1:0] s_addr [3];
  logic [DW-1:0] wdata_in [3];
  logic [DW-1:0] s_wdata [3];
  logic [1:0]    sel;
  logic          fair_take;
  // slot index 0 = host, 1 = data, 2 = fetch (fetch never writes)
  assign req      = {i_req, d_req, h_req};
  assign we_in    = {1'b0, d_we, h_we};
  assign addr_in  = '{h_addr, d_addr, i_addr};
  assign wdata_in = '{h_wdata, d_wdata, {DW{1'b0}}};
  for (genvar g = 0; g < 3; g++) begin : g_slot
    mem_arb_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req[g]),
      .we_i     (we_in[g]),
      .addr_i   (addr_in[g]),
      .wdata_i  (wdata_in[g]),
      .grant_i  (grant[g]),
      .pend_o   (pend[g]),
      .we_o     (s_we[g]),
      .addr_o   (s_addr[g]),
      .wdata_o  (s_wdata[g]),
      .overrun_o(ovr[g])
    );
  end
  assign fair_take = (fair_q == FAIR_LIM) & pend[2] & ~pend[0];
  assign sel       = pend[0] ? 2'd0 : fair_take ? 2'd2 : pend[1] ? 2'd1 : 2'd2;
  assign grant     = (state_q == IDLE && |pend) ? (3'b001 << sel) : 3'b000;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (|pend) begin
        addr_d  = s_addr[sel];
        we_d    = s_we[sel];
        wdata_d = s_wdata[sel];
        owner_d = owner_t'(sel + 2'd1);
        req_d   = ~req_q;
        to_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        to_d = (to_q == TO_LIM) ? to_q : to_q + 1'b1;
        if (ma_answer == req_q) begin
          rdata_d = ma_rdata;
          state_d = DONE;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
    endcase
  end
  assign eov_d  = eov_q | (|ovr);
  assign eto_d  = eto_q | ((TIMEOUT != 0) && state_q == WAIT && to_d == TO_LIM);
  // the streak counter only matters while a fetch is actually waiting
  assign fair_d = (~pend[2] | grant[2]) ? 4'd0 :
                  (grant[1] && fair_q != FAIR_LIM) ? fair_q + 4'd1 : fair_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q    <= '0;
      fair_q  <= '0;
      eov_q   <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
      fair_q  <= fair_d;
      eov_q   <= eov_d;
      eto_q   <= eto_d;
    end
  end
  assign h_done      = (state_q == DONE) && (owner_q == OWN_HOST);
  assign d_done      = (state_q == DONE) && (owner_q == OWN_DATA);
  assign i_done      = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign rdata       = rdata_q;
  assign ma_request  = req_q;
  assign ma_addr     = addr_q;
  assign ma_we       = we_q;
  assign ma_wdata    = wdata_q;
  assign busy        = (state_q != IDLE) || (|pend);
  assign err_overrun = eov_q;
  assign err_timeout = eto_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model and per-cycle compare.
module tb_mem_arbiter;
  localparam int FM = 4;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic h_req = 0, d_req = 0, i_req = 0, h_we = 0, d_we = 0;
  logic [31:0] h_addr = 0, d_addr = 0, i_addr = 0, h_wdata = 0, d_wdata = 0;
  logic h_done, d_done, i_done, ma_request, ma_we, busy, err_overrun, err_timeout;
  logic [31:0] rdata, ma_addr, ma_wdata;
  logic ans;
  logic [31:0] mrdata;
  int lat = 1, wc;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .FAIR_MAX(FM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .h_req(h_req), .d_req(d_req), .i_req(i_req),
    .h_we(h_we), .d_we(d_we), .h_addr(h_addr), .d_addr(d_addr), .i_addr(i_addr),
    .h_wdata(h_wdata), .d_wdata(d_wdata), .h_done(h_done), .d_done(d_done), .i_done(i_done),
    .rdata(rdata), .ma_request(ma_request), .ma_answer(ans), .ma_addr(ma_addr), .ma_we(ma_we),
    .ma_wdata(ma_wdata), .ma_rdata(mrdata), .busy(busy), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEADBEEF : (32'h1000_0000 ^ a);
  endfunction

  // memory: answers lat cycles after it first sees an outstanding request; writes echo wdata
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ans <= 1'b0; wc <= 0; mrdata <= '0;
    end else if (ma_request != ans) begin
      if (wc + 1 >= lat) begin
        ans <= ~ans; wc <= 0;
        mrdata <= ma_we ? ma_wdata : mem_rd(ma_addr);
      end else wc <= wc + 1;
    end
  end

  // reference model: slots per requester, one transaction in flight (ph 0 idle, 1 waiting, 2 done)
  bit mp[3];
  logic [31:0] ma[3], mw[3];
  bit mwe[3];
  int ph, own, tcnt, fair;
  bit mreq, eov, eto;
  logic [31:0] mrd, cur_a, cur_wd;
  bit cur_we;
  logic [31:0] glog[$];
  logic lastreq;
  logic [2:0] dn;

  task automatic model_step();
    bit r[3]; bit old[3]; int g;
    logic [31:0] ain[3]; logic [31:0] win[3]; bit wein[3];
    if (rst) begin
      mp = '{0, 0, 0}; ph = 0; own = -1; tcnt = 0; fair = 0; mreq = 0; eov = 0; eto = 0;
      mrd = 0; cur_a = 0; cur_wd = 0; cur_we = 0;
    end else begin
      r = '{h_req, d_req, i_req}; old = mp; g = -1;
      ain = '{h_addr, d_addr, i_addr}; win = '{h_wdata, d_wdata, 32'h0}; wein = '{h_we, d_we, 1'b0};
      if (ph == 0) begin
        if (old[0]) g = 0;
        else if (old[2] && fair == FM) g = 2;
        else if (old[1]) g = 1;
        else if (old[2]) g = 2;
      end
      if (g >= 0) begin
        own = g; cur_a = ma[g]; cur_we = mwe[g]; cur_wd = mw[g]; mreq = !mreq; ph = 1; tcnt = 0;
      end else if (ph == 1) begin
        tcnt++;
        if (tcnt >= TO) eto = 1;
        if (ans == mreq) begin mrd = mrdata; ph = 2; end
      end else if (ph == 2) begin
        ph = 0; own = -1;
      end
      if (!old[2] || g == 2) fair = 0;
      else if (g == 1 && fair < FM) fair++;
      for (int k = 0; k < 3; k++) begin
        if (g == k) mp[k] = 0;
        if (r[k]) begin
          if (old[k]) eov = 1;
          else begin mp[k] = 1; ma[k] = ain[k]; mw[k] = win[k]; mwe[k] = wein[k]; end
        end
      end
    end
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("h_done", 64'(h_done), 64'(ph == 2 && own == 0));
    chk("d_done", 64'(d_done), 64'(ph == 2 && own == 1));
    chk("i_done", 64'(i_done), 64'(ph == 2 && own == 2));
    if (ph == 2) chk("rdata", 64'(rdata), 64'(mrd));
    chk("ma_request", 64'(ma_request), 64'(mreq));
    if (ph != 0) begin
      chk("ma_addr", 64'(ma_addr), 64'(cur_a));
      chk("ma_we", 64'(ma_we), 64'(cur_we));
      chk("ma_wdata", 64'(ma_wdata), 64'(cur_wd));
    end
    chk("busy", 64'(busy), 64'(ph != 0 || mp[0] || mp[1] || mp[2]));
    chk("err_overrun", 64'(err_overrun), 64'(eov));
    chk("err_timeout", 64'(err_timeout), 64'(eto));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    dn = {i_done, d_done, h_done};
    if (rst) lastreq = 1'b0;
    else begin
      compare();
      if (ma_request !== lastreq) begin glog.push_back(ma_addr); lastreq = ma_request; end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    if (busy) begin checks++; errors++; $display("FAIL drain_bound busy=1 required=0"); end
    repeat (2) tick();
  endtask

  initial begin
    int n, base, kerr, kdone, ndata;
    bit ifin;
    int order[$];
    lastreq = 1'b0;
    tick(); tick();
    chk("rst_ma_request", 64'(ma_request), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    chk("rst_ma_addr", 64'(ma_addr), 64'h0);
    chk("rst_done", 64'({h_done, d_done, i_done}), 64'h0);
    chk("rst_err", 64'({err_overrun, err_timeout}), 64'h0);
    rst = 1'b0;
    repeat (2) tick();

    // single fetch, 1-cycle memory
    i_addr = 32'h40; i_req = 1; tick(); i_req = 0; n = 1;
    while (!dn[2] && n < 50) begin tick(); n++; end
    chk("fetch_latency", 64'(n), 64'd4);
    chk("fetch_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("fetch_ma_request", 64'(ma_request), 64'h1);
    drain();

    // simultaneous requests from all three
    base = glog.size();
    h_addr = 32'h10; h_we = 1; h_wdata = 32'h55; d_addr = 32'h20; d_we = 0; i_addr = 32'h30;
    h_req = 1; d_req = 1; i_req = 1; tick(); h_req = 0; d_req = 0; i_req = 0; h_we = 0; n = 0;
    while (order.size() < 3 && n < 100) begin
      if (dn[0]) order.push_back(0);
      if (dn[1]) begin order.push_back(1); chk("data_rdata", 64'(rdata), 64'h1000_0020); end
      if (dn[2]) order.push_back(2);
      tick(); n++;
    end
    chk("sim_done_count", 64'(order.size()), 64'd3);
    chk("sim_toggles", 64'(glog.size() - base), 64'd3);
    if (order.size() == 3) begin
      chk("sim_order0", 64'(order[0]), 64'd0);
      chk("sim_order1", 64'(order[1]), 64'd1);
      chk("sim_order2", 64'(order[2]), 64'd2);
    end
    if (glog.size() - base == 3) begin
      chk("sim_addr0", 64'(glog[base]), 64'h10);
      chk("sim_addr1", 64'(glog[base+1]), 64'h20);
      chk("sim_addr2", 64'(glog[base+2]), 64'h30);
    end
    drain();

    // starvation: data keeps re-requesting while fetch waits
    base = glog.size(); ifin = 0;
    d_addr = 32'h100; i_addr = 32'h200; d_req = 1; i_req = 1; tick(); i_req = 0; n = 0;
    while (!ifin && n < 400) begin
      d_req = 0;
      if (dn[2]) ifin = 1;
      else if (dn[1]) begin d_addr = d_addr + 4; d_req = 1; end
      if (!ifin) begin tick(); n++; end
    end
    d_req = 0;
    chk("starve_fetch_done", 64'(ifin), 64'h1);
    chk("starve_fair_cnt", 64'(dut.fair_q), 64'h0);
    ndata = 0;
    for (int k = base; k < glog.size() && glog[k] != 32'h200; k++) ndata++;
    chk("starve_data_grants", 64'(ndata), 64'd4);
    drain();

    // overrun: second data req while the slot is still pending
    base = glog.size();
    d_addr = 32'h50; d_req = 1; tick(); d_addr = 32'h60; tick(); d_req = 0;
    drain();
    chk("overrun_flag", 64'(err_overrun), 64'h1);
    chk("overrun_txns", 64'(glog.size() - base), 64'd1);
    if (glog.size() - base == 1) chk("overrun_addr", 64'(glog[base]), 64'h50);

    // timeout: memory withholds its answer for 20 cycles
    lat = 20; kerr = 0; kdone = 0;
    h_addr = 32'h80; h_req = 1; tick(); h_req = 0; n = 1;
    while (!dn[0] && n < 100) begin
      if (err_timeout && kerr == 0) kerr = n;
      tick(); n++;
    end
    if (dn[0]) kdone = n;
    chk("timeout_cycle", 64'(kerr), 64'd10);
    chk("timeout_done", 64'(kdone), 64'd23);
    chk("timeout_rdata", 64'(rdata), 64'h1000_0080);
    drain();

    // reset in the middle of WAIT
    i_addr = 32'h44; i_req = 1; tick(); i_req = 0; repeat (3) tick();
    chk("midwait_busy", 64'(busy), 64'h1);
    rst = 1; tick();
    chk("rstw_ma_request", 64'(ma_request), 64'h0);
    chk("rstw_busy", 64'(busy), 64'h0);
    chk("rstw_answer", 64'(ans), 64'h0);
    chk("rstw_err", 64'({err_overrun, err_timeout}), 64'h0);
    rst = 0; n = 0;
    repeat (30) begin tick(); if (|dn) n++; end
    chk("rstw_no_done", 64'(n), 64'd0);
    chk("rstw_idle_busy", 64'(busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
